// File: rtl/execute_reg.sv
// Decode-to-execute boundary of the PIPE Y86-64 core: operand forwarding into
// the E pipeline register, load/use hazard detection and debug event counters.
module execute_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        E_bubble,
  input  logic [2:0]  D_stat,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [63:0] D_valC,
  input  logic [63:0] D_valP,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  d_dstE,
  input  logic [3:0]  d_dstM,
  input  logic [63:0] d_valA,
  input  logic [63:0] d_valB,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [63:0] M_valE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [63:0] W_valE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valM,
  output logic [2:0]  E_stat,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB,
  output logic        ld_use_hazard,
  output logic [31:0] bubble_cnt,
  output logic [31:0] fwd_cnt
);

  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_POPQ  = 4'hB;
  localparam logic [2:0] S_AOK   = 3'd1;

  logic [63:0] fwd_val_a, fwd_val_b;
  logic        fwd_a, fwd_b;

  // Source ID 15 never matches, so a stage ID of 15 can never match either.
  always_comb begin
    fwd_val_a = d_valA;
    fwd_a     = 1'b0;
    if (D_icode == I_JXX || D_icode == I_CALL) begin
      fwd_val_a = D_valP;
    end else if (d_srcA != RNONE) begin
      fwd_a = 1'b1;
      if      (d_srcA == e_dstE) fwd_val_a = e_valE;
      else if (d_srcA == M_dstM) fwd_val_a = m_valM;
      else if (d_srcA == M_dstE) fwd_val_a = M_valE;
      else if (d_srcA == W_dstM) fwd_val_a = W_valM;
      else if (d_srcA == W_dstE) fwd_val_a = W_valE;
      else                       fwd_a     = 1'b0;
    end
  end

  always_comb begin
    fwd_val_b = d_valB;
    fwd_b     = 1'b0;
    if (d_srcB != RNONE) begin
      fwd_b = 1'b1;
      if      (d_srcB == e_dstE) fwd_val_b = e_valE;
      else if (d_srcB == M_dstM) fwd_val_b = m_valM;
      else if (d_srcB == M_dstE) fwd_val_b = M_valE;
      else if (d_srcB == W_dstM) fwd_val_b = W_valM;
      else if (d_srcB == W_dstE) fwd_val_b = W_valE;
      else                       fwd_b     = 1'b0;
    end
  end

  always_comb begin
    ld_use_hazard = (E_icode == I_MRMOV || E_icode == I_POPQ) && (E_dstM != RNONE) &&
                    (E_dstM == d_srcA || E_dstM == d_srcB);
  end

  always_ff @(posedge clk) begin
    if (rst || E_bubble) begin
      E_stat  <= S_AOK;
      E_icode <= I_NOP;
      E_ifun  <= '0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else begin
      E_stat  <= D_stat;
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_valC  <= D_valC;
      E_valA  <= fwd_val_a;
      E_valB  <= fwd_val_b;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      fwd_cnt    <= '0;
    end else if (E_bubble) begin
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 32'd1;
    end else if (fwd_a || fwd_b) begin
      if (fwd_cnt != '1) fwd_cnt <= fwd_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_execute_reg.sv
// Directed self-checking bench for execute_reg: reset, forwarding priority,
// valP rule, load/use hazard, bubbles and counter saturation.
module tb_execute_reg;

  logic        clk = 1'b0;
  logic        rst, E_bubble;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun;
  logic [63:0] D_valC, D_valP;
  logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valA, d_valB;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;
  logic        ld_use_hazard;
  logic [31:0] bubble_cnt, fwd_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  execute_reg dut (
    .clk(clk), .rst(rst), .E_bubble(E_bubble),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_valC(D_valC), .D_valP(D_valP),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_valA(d_valA), .d_valB(d_valB),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .ld_use_hazard(ld_use_hazard), .bubble_cnt(bubble_cnt), .fwd_cnt(fwd_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stages();
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
  endtask

  initial begin
    rst = 1'b1; E_bubble = 1'b0;
    D_stat = 3'd2; D_icode = 4'h6; D_ifun = 4'h3;
    D_valC = 64'h1234; D_valP = 64'h99;
    d_srcA = 4'h1; d_srcB = 4'h2; d_dstE = 4'h2; d_dstM = 4'h3;
    d_valA = 64'h5555; d_valB = 64'h6666;
    e_valE = 64'hAA; M_valE = 64'hDD; m_valM = 64'hBB; W_valE = 64'hCC; W_valM = 64'hEE;
    clear_stages();

    // Reset with arbitrary D contents
    step();
    check("rst_icode", E_icode, 64'h1);
    check("rst_stat",  E_stat,  64'h1);
    check("rst_dstE",  E_dstE,  64'hF);
    check("rst_dstM",  E_dstM,  64'hF);
    check("rst_srcA",  E_srcA,  64'hF);
    check("rst_srcB",  E_srcB,  64'hF);
    check("rst_valA",  E_valA,  64'h0);
    check("rst_bcnt",  bubble_cnt, 64'h0);
    check("rst_fcnt",  fwd_cnt, 64'h0);

    // Plain load, no stage matches
    rst = 1'b0;
    D_stat = 3'd1; D_icode = 4'h6; D_ifun = 4'h0;
    d_srcA = 4'h2; d_srcB = 4'h3; d_dstE = 4'h3; d_dstM = 4'hF;
    d_valA = 64'h11; d_valB = 64'h22;
    step();
    check("load_icode", E_icode, 64'h6);
    check("load_valA",  E_valA,  64'h11);
    check("load_valB",  E_valB,  64'h22);
    check("load_dstE",  E_dstE,  64'h3);
    check("load_fcnt",  fwd_cnt, 64'h0);

    // Priority chain on valA
    d_srcA = 4'h5; e_dstE = 4'h5; M_dstM = 4'h5; W_dstE = 4'h5;
    step();
    check("pri_e",      E_valA,  64'hAA);
    check("pri_e_fcnt", fwd_cnt, 64'h1);
    e_dstE = 4'hF;
    step();
    check("pri_mM",      E_valA,  64'hBB);
    check("pri_mM_fcnt", fwd_cnt, 64'h2);
    M_dstM = 4'hF; M_dstE = 4'h5;
    step();
    check("pri_mE", E_valA, 64'hDD);
    M_dstE = 4'hF; W_dstM = 4'h5;
    step();
    check("pri_wM", E_valA, 64'hEE);
    W_dstM = 4'hF;
    step();
    check("pri_wE",      E_valA,  64'hCC);
    check("pri_wE_fcnt", fwd_cnt, 64'h5);

    // valB forwarding, valA from register file
    clear_stages();
    d_srcA = 4'h2; d_srcB = 4'h6; W_dstE = 4'h6; W_valE = 64'h66;
    step();
    check("fwdB_valB", E_valB,  64'h66);
    check("fwdB_valA", E_valA,  64'h11);
    check("fwdB_fcnt", fwd_cnt, 64'h6);

    // valP rule
    clear_stages();
    D_icode = 4'h8; D_valP = 64'h40; d_srcA = 4'hF; d_srcB = 4'h3;
    step();
    check("call_valA", E_valA,  64'h40);
    check("call_fcnt", fwd_cnt, 64'h6);
    D_icode = 4'h7; d_srcA = 4'h2; e_dstE = 4'h2;
    step();
    check("jxx_valA", E_valA,  64'h40);
    check("jxx_fcnt", fwd_cnt, 64'h6);

    // Load/use hazard
    clear_stages();
    D_icode = 4'h5; d_dstM = 4'h4; d_srcA = 4'hF; d_srcB = 4'hF;
    step();
    check("lu_icode", E_icode, 64'h5);
    d_srcB = 4'h4; #1;
    check("lu_hit_B", ld_use_hazard, 64'h1);
    d_srcB = 4'h7; #1;
    check("lu_miss", ld_use_hazard, 64'h0);
    D_icode = 4'h5; d_dstM = 4'hF;
    step();
    d_srcB = 4'h4; #1;
    check("lu_dstM_none", ld_use_hazard, 64'h0);
    D_icode = 4'h6; d_dstM = 4'h4; d_srcB = 4'hF;
    step();
    d_srcB = 4'h4; #1;
    check("lu_opq", ld_use_hazard, 64'h0);
    D_icode = 4'hB; d_dstM = 4'h4; d_srcB = 4'hF;
    step();
    d_srcA = 4'h4; #1;
    check("lu_pop_A", ld_use_hazard, 64'h1);

    // Bubbles with a live forward match: no forward counted
    d_srcA = 4'h2; d_srcB = 4'hF; e_dstE = 4'h2; E_bubble = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bub_icode", E_icode, 64'h1);
      check("bub_dstE",  E_dstE,  64'hF);
    end
    check("bub_cnt3",  bubble_cnt, 64'h3);
    check("bub_fcnt",  fwd_cnt,    64'h6);

    // Saturation near the top of bubble_cnt
    force dut.bubble_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_cnt;
    step();
    check("sat_max",  bubble_cnt, 64'hFFFF_FFFF);
    step();
    check("sat_hold", bubble_cnt, 64'hFFFF_FFFF);

    // Reset mid-stream discards the presented instruction
    E_bubble = 1'b0; D_icode = 4'h6; d_dstE = 4'h3; rst = 1'b1;
    step();
    check("rst2_icode", E_icode,    64'h1);
    check("rst2_dstE",  E_dstE,     64'hF);
    check("rst2_bcnt",  bubble_cnt, 64'h0);
    check("rst2_fcnt",  fwd_cnt,    64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_reg.md
# execute_reg

Decode-to-execute boundary of the PIPE Y86-64 core. Takes the decode stage's register-ID and register-value outputs, applies the standard Y86-64 operand forwarding (Sel+Fwd A and Fwd B), and captures the result in the E pipeline register on each clock, with bubble injection from pipeline control. It also flags load/use hazards for pipeline control and keeps bubble/forward event counters for debug.

## Interface
- No parameters. Widths are fixed: icode/ifun/reg IDs 4 bits, data 64 bits, stat 3 bits.
- clk  in  1  single pipeline clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- E_bubble  in  1  load a nop bubble instead of decode contents
- D_stat  in  3  decode-stage status (1 AOK, 2 HLT, 3 ADR, 4 INS)
- D_icode, D_ifun  in  4 each  decode-stage instruction fields
- D_valC, D_valP  in  64 each  constant and incremented PC
- d_srcA, d_srcB, d_dstE, d_dstM  in  4 each  decode register IDs; 15 = none
- d_valA, d_valB  in  64 each  register-file read values
- e_dstE, e_valE  in  4/64  execute-stage write target and ALU result
- M_dstE, M_valE, M_dstM, m_valM  in  4/64/4/64  memory-stage targets and values
- W_dstE, W_valE, W_dstM, W_valM  in  4/64/4/64  write-back targets and values
- E_stat  out  3; E_icode, E_ifun  out  4; E_valC, E_valA, E_valB  out  64; E_dstE, E_dstM, E_srcA, E_srcB  out  4  registered E-stage fields
- ld_use_hazard  out  1  combinational load/use hazard flag
- bubble_cnt, fwd_cnt  out  32 each  saturating event counters

## Operation
- Forwarded valA, evaluated combinationally in priority order:
  - D_icode 7 (jXX) or 8 (call) → D_valP
  - d_srcA == e_dstE → e_valE
  - == M_dstM → m_valM
  - == M_dstE → M_valE
  - == W_dstM → W_valM
  - == W_dstE → W_valE
  - otherwise d_valA
- Forwarded valB: same chain without the valP rule, keyed on d_srcB, default d_valB.
- ID 15 never matches. If d_src is 15, or a stage ID is 15, that comparison is false.
- Bubble contents: stat 1, icode 1 (nop), ifun 0, valC/valA/valB 0, all four reg IDs 15.
- Clock edge, priority rst > E_bubble > load:
  - rst → bubble contents, and both counters cleared to 0.
  - E_bubble → bubble contents.
  - Otherwise E_* ← D_stat, D_icode, D_ifun, D_valC, forwarded valA, forwarded valB, d_dstE, d_dstM, d_srcA, d_srcB.
- ld_use_hazard = (E_icode == 5 or E_icode == 11) and E_dstM != 15 and (E_dstM == d_srcA or E_dstM == d_srcB).
  - Purely combinational from current E register and d_src inputs.
  - Not gated by E_bubble.
- bubble_cnt: +1 on each non-reset edge with E_bubble = 1.
- fwd_cnt: +1 on each non-reset loading edge (E_bubble = 0) where valA or valB took any forwarded source, i.e. not d_valA/d_valB and not the valP rule. It increments once even if both operands forwarded.
- Both counters saturate at 0xFFFF_FFFF with no wrap.

## Timing
- Latency: D inputs on edge n appear on E_* after edge n; one cycle, no stall input (E never stalls in PIPE).
- All E_* outputs and counters are registered. The forwarding mux and ld_use_hazard are combinational, with no internal feedback from E_* into the valA/valB mux.
- Reset mid-stream: the instruction presented at that edge is discarded, and E shows the nop bubble from the next cycle.
- E_bubble held for k edges inserts k bubbles; bubble_cnt += k.
- Simultaneous match in several stages: the highest-priority stage wins (e over M over W; M_dstM over M_dstE; W_dstM over W_dstE).

## Test plan
- Reset: rst=1 for one edge with arbitrary D inputs → E_icode=1, E_stat=1, E_dstE/E_dstM/E_srcA/E_srcB=15, E_valA=0, counters=0.
- Plain load: D_icode=6, d_srcA=2, d_srcB=3, d_valA=0x11, d_valB=0x22, no stage matches → next cycle E_valA=0x11, E_valB=0x22, E_dstE=3, fwd_cnt unchanged.
- Priority: d_srcA=5, e_dstE=5/e_valE=0xAA, M_dstM=5/m_valM=0xBB, W_dstE=5 → E_valA=0xAA. Remove the e match → 0xBB. fwd_cnt +1 per edge.
- valP rule: D_icode=8, D_valP=0x40, d_srcA=15 → E_valA=0x40. D_icode=7 with e_dstE matching d_srcA → still E_valA=D_valP, and fwd_cnt unchanged.
- Load/use: E holds icode 5 with E_dstM=4, drive d_srcB=4 → ld_use_hazard=1. d_srcB=4 with E_dstM=15, or E_icode=6 → 0.
- Bubble/saturation: E_bubble=1 for 3 edges → three nop cycles, bubble_cnt=3. Preload the counter near max via 2^32+ bubbles in a long run (or force) → it holds at 0xFFFF_FFFF.
